// File: rtl/sparc_ifu_parseq_if.sv
// Request/slice/result bundle for the IFU parity check sequencer.
// slave: the sequencer side. master: the requesters, slice and result consumer.
interface sparc_ifu_parseq_if #(
  parameter int NCHUNK = 4
);
  logic                   fil_req_vld;
  logic                   fil_req_rdy;
  logic [16*NCHUNK-1:0]   fil_data;
  logic [NCHUNK-1:0]      fil_par;
  logic                   dgn_req_vld;
  logic                   dgn_req_rdy;
  logic [16*NCHUNK-1:0]   dgn_data;
  logic [NCHUNK-1:0]      dgn_par;
  logic [15:0]            par16_in;
  logic                   par16_out;
  logic                   res_vld;
  logic                   res_src;
  logic [NCHUNK-1:0]      res_par;
  logic [NCHUNK-1:0]      res_perr;
  logic                   res_ack;

  modport slave (
    input  fil_req_vld, fil_data, fil_par,
    input  dgn_req_vld, dgn_data, dgn_par,
    input  par16_out, res_ack,
    output fil_req_rdy, dgn_req_rdy, par16_in,
    output res_vld, res_src, res_par, res_perr
  );

  modport master (
    output fil_req_vld, fil_data, fil_par,
    output dgn_req_vld, dgn_data, dgn_par,
    output par16_out, res_ack,
    input  fil_req_rdy, dgn_req_rdy, par16_in,
    input  res_vld, res_src, res_par, res_perr
  );
endinterface

// File: rtl/sparc_ifu_parseq.sv
// IFU parity check sequencer: arbitrates fill and diag requests onto one
// shared 16-bit parity slice, walks the word one chunk per cycle, and holds
// the computed parity / mismatch result until acknowledged.
// Optional feature: define IFU_PARSEQ_ERRINJ_EN to add the errinj input,
// which forces a chunk-0 parity error on the next granted request.
module sparc_ifu_parseq #(
  parameter int NCHUNK   = 4,
  parameter int FAIR_LIM = 2
) (
  input  logic                     rclk,
  input  logic                     arst_l,
`ifdef IFU_PARSEQ_ERRINJ_EN
  input  logic                     errinj,
`endif
  sparc_ifu_parseq_if.slave        bus
);

  localparam int          CW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [2:0]  FLIM = 3'(FAIR_LIM);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               fcnt_q, fcnt_d;
  logic [NCHUNK-1:0][15:0]  data_q;
  logic [NCHUNK-1:0]        spar_q;
  logic [NCHUNK-1:0]        par_q;
  logic [NCHUNK-1:0]        perr_q;
  logic                     src_q;
  logic                     fil_gnt, dgn_gnt, gnt, starve;
  logic [15:0]              slice_op;
  logic                     cap;

  assign starve = (fcnt_q >= FLIM);
  assign gnt    = fil_gnt | dgn_gnt;

  // Arbitration, chunk walk and starvation counter next-state.
  // Grants are gated by arst_l so nothing is offered while reset is held.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    fil_gnt  = 1'b0;
    dgn_gnt  = 1'b0;
    slice_op = 16'h0;
    case (state_q)
      IDLE: begin
        fil_gnt = arst_l & bus.fil_req_vld & ~(bus.dgn_req_vld & starve);
        dgn_gnt = arst_l & bus.dgn_req_vld & ~fil_gnt;
        if (fil_gnt | dgn_gnt) begin
          state_d = CALC;
          cnt_d   = '0;
        end
      end
      CALC: begin
        slice_op = data_q[cnt_q];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (bus.res_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A diag that stops waiting or gets served resets the fairness window.
    if (!bus.dgn_req_vld || dgn_gnt) fcnt_d = '0;
    else if (fil_gnt)                fcnt_d = fcnt_q + 3'd1;
  end

  // FSM, chunk counter and fairness counter registers.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef IFU_PARSEQ_ERRINJ_EN
  logic inj_arm_q, inj_req_q;

  // Sticky arm flag; the next grant (including one in the same cycle as
  // the pulse) takes it and marks that request for chunk-0 inversion.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      inj_arm_q <= 1'b0;
      inj_req_q <= 1'b0;
    end else if (gnt) begin
      inj_req_q <= inj_arm_q | errinj;
      inj_arm_q <= 1'b0;
    end else if (errinj) begin
      inj_arm_q <= 1'b1;
    end
  end

  assign cap = bus.par16_out ^ (inj_req_q & (cnt_q == '0));
`else
  assign cap = bus.par16_out;
`endif

  // Request capture on grant, then one parity bit per CALC cycle.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      data_q <= '0;
      spar_q <= '0;
      src_q  <= 1'b0;
      par_q  <= '0;
      perr_q <= '0;
    end else if (gnt) begin
      data_q <= dgn_gnt ? bus.dgn_data : bus.fil_data;
      spar_q <= dgn_gnt ? bus.dgn_par  : bus.fil_par;
      src_q  <= dgn_gnt;
      par_q  <= '0;
      perr_q <= '0;
    end else if (state_q == CALC) begin
      par_q[cnt_q]  <= cap;
      perr_q[cnt_q] <= cap ^ spar_q[cnt_q];
    end
  end

  assign bus.fil_req_rdy = fil_gnt;
  assign bus.dgn_req_rdy = dgn_gnt;
  assign bus.par16_in    = slice_op;
  assign bus.res_vld     = (state_q == DONE);
  assign bus.res_src     = src_q;
  assign bus.res_par     = par_q;
  assign bus.res_perr    = perr_q;

endmodule

// File: doc/sparc_ifu_parseq.md
# sparc_ifu_parseq

Parity check sequencer for the IFU. It accepts 64-bit words with 4 stored parity bits from two requesters: the I-cache fill path and the diagnostic/ASI path. Requesters are arbitrated onto one shared external 16-bit parity slice, four chunks over four cycles. The block compares the computed parity against the stored bits and returns a held result under a valid/ack handshake.

## Interface
- NCHUNK, 4, number of 16-bit chunks per word; data width is 16*NCHUNK; legal range 2..8.
- FAIR_LIM, 2, consecutive fill grants allowed while a diag request waits; legal range 1..7.

- rclk  in  1  clock.
- arst_l  in  1  reset; asynchronous, active-low.
- fil_req_vld  in  1  fill request valid.
- fil_req_rdy  out  1  fill grant; a transfer occurs when vld & rdy.
- fil_data  in  16*NCHUNK  fill data; chunk k is bits [16k+15:16k].
- fil_par  in  NCHUNK  stored fill parity; bit k is odd parity of chunk k.
- dgn_req_vld  in  1  diag request valid.
- dgn_req_rdy  out  1  diag grant.
- dgn_data  in  16*NCHUNK  diag data.
- dgn_par  in  NCHUNK  stored diag parity.
- par16_in  out  16  operand to the shared parity slice.
- par16_out  in  1  slice result, combinational XOR-reduce of par16_in.
- res_vld  out  1  result valid.
- res_src  out  1  result source: 0 = fill, 1 = diag.
- res_par  out  NCHUNK  computed parity.
- res_perr  out  NCHUNK  per-chunk mismatch (computed XOR stored).
- res_ack  in  1  result consumed.

## Operation
- State machine has three states: IDLE, CALC, DONE. A chunk counter cnt runs 0..NCHUNK-1.
- **IDLE grants:**
  - fil_req_rdy = IDLE & fil_req_vld & ~(dgn_req_vld & starve).
  - dgn_req_rdy = IDLE & dgn_req_vld & ~fil_req_rdy.
  - At most one grant per cycle. Fill wins by default.
- **Starvation guard:**
  - fcnt increments on each fill grant made while dgn_req_vld=1.
  - fcnt clears on a diag grant, and on any cycle with dgn_req_vld=0.
  - starve = (fcnt >= FAIR_LIM).
- **On a grant:**
  - Data, stored parity and source are registered.
  - State goes to CALC with cnt=0.
  - res_par and res_perr clear.
- **CALC:**
  - par16_in = registered chunk[cnt].
  - On each edge, res_par[cnt] <= par16_out and res_perr[cnt] <= par16_out ^ stored_par[cnt]; then cnt increments.
  - After cnt = NCHUNK-1 is captured, state goes to DONE.
- **DONE:**
  - res_vld=1. res_src, res_par and res_perr are held stable.
  - res_ack=1 moves the state to IDLE on that edge.
  - res_ack is ignored outside DONE.
- par16_in is 0 outside CALC.
- Requesters must hold vld, data and par until granted. Dropping vld before the grant withdraws the request with no side effect.

## Timing
- Grant occurs in cycle T (combinational rdy).
- Chunk k is on par16_in in cycle T+1+k.
- res_vld rises in cycle T+1+NCHUNK (T+5 at default).
- With res_ack in the first DONE cycle, the next grant can occur in T+2+NCHUNK. Minimum spacing is NCHUNK+2 cycles.
- **Reset (arst_l low):** asynchronous at any time, including mid-CALC or DONE.
  - State goes to IDLE; cnt=0, fcnt=0.
  - res_vld=0, res_src=0, res_par=0, res_perr=0, par16_in=0, fil_req_rdy=0, dgn_req_rdy=0.
  - An in-flight request is lost. The requester re-presents it after reset.
- **Simultaneous events:**
  - Both vld high with starve=0: fill granted.
  - Both vld high with starve=1: diag granted and fcnt clears.
  - res_ack and new vld in the same DONE cycle: no grant that cycle. The grant occurs the following IDLE cycle.

## Configuration
- IFU_PARSEQ_ERRINJ_EN defined:
  - Adds input errinj (1 bit).
  - A pulse on errinj arms a sticky flag. The flag is consumed by the next grant.
  - For that request, chunk 0's captured parity is inverted, so res_par[0] flips and res_perr[0]=1 on correct data.
  - Reset clears the flag.
  - A pulse coinciding with a grant applies to that grant.
- Not defined:
  - errinj port is absent; no injection logic exists.
  - Results always reflect the true parity.

## Test plan
- **Reset and single fill:** Reset, then fill data=0x0001_0003_0000_FFFF with par=4'b1000 → res_vld at T+5, res_par=4'b1000, res_perr=0, res_src=0.
- **Single-chunk error:** Fill data=0x0000_0000_0000_0001 with par=0 → res_par=4'b0001, res_perr=4'b0001; the result holds until res_ack.
- **Fairness:** Fill and diag both held continuously → grant order fill, fill, diag, fill, fill, diag (FAIR_LIM=2). Each result src matches its grant.
- **Reset mid-CALC:** Assert arst_l low during cycle T+2 → all outputs 0 immediately. After release, a new request completes normally with spacing NCHUNK+2.
- **Ack/request overlap:** res_ack together with fil_req_vld in DONE → fil_req_rdy=0 that cycle and 1 the next cycle.
- **Error injection (IFU_PARSEQ_ERRINJ_EN):** errinj pulse, then fill of all-zero data with par=0 → res_perr=4'b0001. The following identical request gives res_perr=0.
